// File: rtl/gshare_bp_if.sv
// Fetch/retire bundle between the IF/ROB side and the gshare predictor.
interface gshare_bp_if #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned HIST_BITS = 6,
  parameter int unsigned STAT_BITS = 32
) ();
  logic [WIDTH-1:0]           if_valid_cond;
  logic [64*WIDTH-1:0]        if_NPC;
  logic                       if_stall;
  logic                       recover_cond;
  logic [WIDTH-1:0]           rob_retire_cond;
  logic [64*WIDTH-1:0]        rob_retire_NPC;
  logic [HIST_BITS*WIDTH-1:0] rob_retire_BHR;
  logic [WIDTH-1:0]           rob_actual_taken;
  logic [WIDTH-1:0]           if_branch_taken;
  logic [HIST_BITS*WIDTH-1:0] id_bhr;
  logic [STAT_BITS-1:0]       stat_branches;
  logic [STAT_BITS-1:0]       stat_recovers;

  modport master (
    output if_valid_cond, if_NPC, if_stall, recover_cond,
    output rob_retire_cond, rob_retire_NPC, rob_retire_BHR, rob_actual_taken,
    input  if_branch_taken, id_bhr, stat_branches, stat_recovers
  );

  modport slave (
    input  if_valid_cond, if_NPC, if_stall, recover_cond,
    input  rob_retire_cond, rob_retire_NPC, rob_retire_BHR, rob_actual_taken,
    output if_branch_taken, id_bhr, stat_branches, stat_recovers
  );
endinterface

// File: rtl/gshare_bp.sv
// Multi-slot gshare predictor: speculative fetch-time history, architectural history
// rebuilt from retired outcomes, saturating counter table and saturating stats.
module gshare_bp #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned HIST_BITS = 6,
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned STAT_BITS = 32
) (
  input logic        clock,
  input logic        reset,
  gshare_bp_if.slave bp
);

  localparam int unsigned Depth   = 2 ** IDX_BITS;
  localparam int unsigned MinBits = (HIST_BITS < IDX_BITS) ? HIST_BITS : IDX_BITS;
  localparam logic [CTR_BITS-1:0]  Wnt    = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CtrOne = CTR_BITS'(1);
  localparam logic [STAT_BITS:0]   CntOne = (STAT_BITS + 1)'(1);
  localparam logic [STAT_BITS-1:0] StatOne = STAT_BITS'(1);

  // History is zero-extended or truncated to the index width before the XOR.
  function automatic logic [IDX_BITS-1:0] f_idx(input logic [63:0]          pc,
                                                input logic [HIST_BITS-1:0] h);
    logic [IDX_BITS-1:0] hx;
    hx = '0;
    hx[MinBits-1:0] = h[MinBits-1:0];
    return pc[IDX_BITS+1:2] ^ hx;
  endfunction

  logic [CTR_BITS-1:0]        r_ctr [Depth];
  logic [HIST_BITS-1:0]       r_spec_hist;
  logic [HIST_BITS-1:0]       r_arch_hist;
  logic [STAT_BITS-1:0]       r_stat_branches;
  logic [STAT_BITS-1:0]       r_stat_recovers;

  logic [CTR_BITS-1:0]        w_ctr_d [Depth];
  logic [HIST_BITS-1:0]       w_arch_d;
  logic [HIST_BITS-1:0]       w_spec_d;
  logic [HIST_BITS-1:0]       w_walk_hist;
  logic [WIDTH-1:0]           w_pred;
  logic [HIST_BITS*WIDTH-1:0] w_id_bhr;
  logic [STAT_BITS-1:0]       w_stat_branches_d;
  logic [STAT_BITS-1:0]       w_stat_recovers_d;

  // Fetch walk: slots after the first predicted-taken one are dead.
  always_comb begin
    logic [HIST_BITS-1:0] h;
    logic                 dead;
    logic                 t;
    h        = r_spec_hist;
    dead     = 1'b0;
    t        = 1'b0;
    w_pred   = '0;
    w_id_bhr = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      w_id_bhr[k*HIST_BITS +: HIST_BITS] = h;
      if (bp.if_valid_cond[k] && !dead) begin
        t         = r_ctr[f_idx(bp.if_NPC[k*64 +: 64], h)][CTR_BITS-1];
        w_pred[k] = t;
        h         = {h[HIST_BITS-2:0], t};
        dead      = t;
      end
    end
    w_walk_hist = h;
  end

  // Retire updates compose in slot order so repeated hits on one entry accumulate.
  always_comb begin
    logic [IDX_BITS-1:0]  idx;
    logic [CTR_BITS-1:0]  c;
    logic [HIST_BITS-1:0] a;
    logic [STAT_BITS:0]   n;
    logic [STAT_BITS:0]   sum;
    w_ctr_d = r_ctr;
    a       = r_arch_hist;
    n       = '0;
    idx     = '0;
    c       = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (bp.rob_retire_cond[k]) begin
        idx = f_idx(bp.rob_retire_NPC[k*64 +: 64], bp.rob_retire_BHR[k*HIST_BITS +: HIST_BITS]);
        c   = w_ctr_d[idx];
        if (bp.rob_actual_taken[k]) begin
          if (c != '1) c = c + CtrOne;
        end else begin
          if (c != '0) c = c - CtrOne;
        end
        w_ctr_d[idx] = c;
        a = {a[HIST_BITS-2:0], bp.rob_actual_taken[k]};
        n = n + CntOne;
      end
    end
    w_arch_d = a;

    sum = {1'b0, r_stat_branches} + n;
    w_stat_branches_d = sum[STAT_BITS] ? '1 : sum[STAT_BITS-1:0];
    w_stat_recovers_d = r_stat_recovers;
    if (bp.recover_cond && (r_stat_recovers != '1)) begin
      w_stat_recovers_d = r_stat_recovers + StatOne;
    end

    if (bp.recover_cond) begin
      w_spec_d = w_arch_d;
    end else if (bp.if_stall) begin
      w_spec_d = r_spec_hist;
    end else begin
      w_spec_d = w_walk_hist;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_ctr[i] <= Wnt;
      end
      r_spec_hist     <= '0;
      r_arch_hist     <= '0;
      r_stat_branches <= '0;
      r_stat_recovers <= '0;
    end else begin
      r_ctr           <= w_ctr_d;
      r_spec_hist     <= w_spec_d;
      r_arch_hist     <= w_arch_d;
      r_stat_branches <= w_stat_branches_d;
      r_stat_recovers <= w_stat_recovers_d;
    end
  end

  assign bp.if_branch_taken = bp.recover_cond ? '0 : w_pred;
  assign bp.id_bhr          = w_id_bhr;
  assign bp.stat_branches   = r_stat_branches;
  assign bp.stat_recovers   = r_stat_recovers;

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp (WIDTH=2, HIST_BITS=6, STAT_BITS=4) with an expectation queue.
module tb_gshare_bp;

  localparam int unsigned W  = 2;
  localparam int unsigned HB = 6;
  localparam int unsigned SB = 4;
  localparam int SelPred = 0;
  localparam int SelBhr  = 1;
  localparam int SelBr   = 2;
  localparam int SelRec  = 3;

  logic clk;
  logic rst_n;

  gshare_bp_if #(.WIDTH(W), .HIST_BITS(HB), .STAT_BITS(SB)) bp_bus ();

  gshare_bp #(
    .WIDTH    (W),
    .HIST_BITS(HB),
    .IDX_BITS (6),
    .CTR_BITS (2),
    .STAT_BITS(SB)
  ) u_dut (
    .clock(clk),
    .reset(rst_n),
    .bp   (bp_bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SelPred: return 64'(bp_bus.if_branch_taken);
      SelBhr:  return 64'(bp_bus.id_bhr);
      SelBr:   return 64'(bp_bus.stat_branches);
      SelRec:  return 64'(bp_bus.stat_recovers);
      default: return 64'hdead;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    sb.push_back('{tag: tag, sel: sel, exp: exp});
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic stall);
    bp_bus.if_valid_cond = v;
    bp_bus.if_NPC        = {pc1, pc0};
    bp_bus.if_stall      = stall;
  endtask

  task automatic retire(input logic [1:0] c, input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [5:0] h0, input logic [5:0] h1, input logic [1:0] t);
    bp_bus.rob_retire_cond  = c;
    bp_bus.rob_retire_NPC   = {pc1, pc0};
    bp_bus.rob_retire_BHR   = {h1, h0};
    bp_bus.rob_actual_taken = t;
  endtask

  task automatic idle();
    fetch(2'b00, 64'h0, 64'h0, 1'b0);
    retire(2'b00, 64'h0, 64'h0, 6'h0, 6'h0, 2'b00);
    bp_bus.recover_cond = 1'b0;
  endtask

  initial begin
    logic [5:0] s_model;
    logic [5:0] pat;
    logic [5:0] nt_taken;
    logic [5:0] nt_pred;
    logic [63:0] pc;
    int v;

    rst_n = 1'b0;
    idle();
    push("rst_pred", SelPred, 64'h0);
    push("rst_bhr", SelBhr, 64'h0);
    push("rst_br", SelBr, 64'h0);
    push("rst_rec", SelRec, 64'h0);
    drain();
    cyc();
    rst_n = 1'b1;

    // First fetch after reset: weakly-not-taken everywhere.
    fetch(2'b11, 64'h100, 64'h104, 1'b0);
    push("init_pred", SelPred, 64'h0);
    push("init_bhr", SelBhr, 64'h0);
    drain();
    cyc();
    idle();
    push("init_hist", SelBhr, 64'h0);
    drain();

    // Two takens on the same entry in one cycle: 1 -> 3.
    retire(2'b11, 64'h100, 64'h100, 6'h0, 6'h0, 2'b11);
    cyc();
    idle();
    push("br_two", SelBr, 64'h2);
    drain();

    fetch(2'b11, 64'h100, 64'h104, 1'b0);
    push("dead_pred", SelPred, 64'h1);
    push("dead_bhr", SelBhr, 64'h040);
    drain();
    cyc();
    idle();
    push("hist_01", SelBhr, 64'h041);
    drain();

    // Stalled fetch at index 0 (pc bits 000001 ^ hist 000001) observes the counter MSB.
    fetch(2'b01, 64'h104, 64'h0, 1'b1);
    retire(2'b11, 64'h100, 64'h100, 6'h0, 6'h0, 2'b11);
    push("sat_hi_pre", SelPred, 64'h1);
    drain();
    cyc();
    nt_taken = 6'b110000;
    nt_pred  = 6'b000011;
    for (int i = 0; i < 6; i++) begin
      retire(2'b01, 64'h100, 64'h0, 6'h0, 6'h0, {1'b0, nt_taken[i]});
      push("ctr_walk", SelPred, 64'(nt_pred[i]));
      drain();
      cyc();
    end
    retire(2'b00, 64'h0, 64'h0, 6'h0, 6'h0, 2'b00);
    push("ctr_rise", SelPred, 64'h1);
    push("stall_bhr", SelBhr, 64'h0C1);
    push("br_ten", SelBr, 64'hA);
    drain();
    cyc();

    // Steer spec_hist to 101010 using idx0 (taken) and idx1 (not taken).
    idle();
    s_model = 6'b000001;
    pat     = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      pc = 64'(s_model ^ (pat[i] ? 6'd0 : 6'd1)) << 2;
      fetch(2'b01, pc, 64'h0, 1'b0);
      push("fill_pred", SelPred, 64'(pat[i]));
      drain();
      cyc();
      s_model = {s_model[4:0], pat[i]};
    end
    idle();
    push("hist_2a", SelBhr, 64'hAAA);
    drain();

    // arch_hist is 000011 here; retire T,NT with recovery -> 001110.
    fetch(2'b11, 64'hA8, 64'hAC, 1'b0);
    bp_bus.recover_cond = 1'b1;
    retire(2'b11, 64'h108, 64'h10C, 6'h0, 6'h0, 2'b01);
    push("rec_pred", SelPred, 64'h0);
    drain();
    cyc();
    idle();
    push("rec_hist", SelBhr, 64'h38E);
    push("rec_cnt", SelRec, 64'h1);
    push("rec_br", SelBr, 64'hC);
    drain();

    fetch(2'b01, 64'h30, 64'h0, 1'b0);
    push("idx2_pred", SelPred, 64'h1);
    drain();
    cyc();
    idle();
    push("pre_stallrec", SelBhr, 64'h75D);
    drain();
    fetch(2'b01, 64'h30, 64'h0, 1'b1);
    bp_bus.recover_cond = 1'b1;
    push("stallrec_pred", SelPred, 64'h0);
    drain();
    cyc();
    idle();
    push("stallrec_hist", SelBhr, 64'h38E);
    push("stallrec_cnt", SelRec, 64'h2);
    drain();

    for (int i = 0; i < 3; i++) begin
      retire(2'b11, 64'h140, 64'h144, 6'h0, 6'h0, 2'b11);
      cyc();
      idle();
      v = 12 + 2 * (i + 1);
      if (v > 15) v = 15;
      push("br_sat", SelBr, 64'(v));
      drain();
    end

    // Asynchronous reset between edges; idx2 was 2 and must read back weakly not-taken.
    rst_n = 1'b0;
    fetch(2'b01, 64'h08, 64'h0, 1'b0);
    push("arst_pred", SelPred, 64'h0);
    push("arst_bhr", SelBhr, 64'h0);
    push("arst_br", SelBr, 64'h0);
    push("arst_rec", SelRec, 64'h0);
    drain();
    cyc();
    rst_n = 1'b1;
    #1;
    push("post_rst_pred", SelPred, 64'h0);
    push("post_rst_br", SelBr, 64'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
